seq_lock_checker: RTL and testbench
===================================

// Module: seq_lock_checker
// PURPOSE
//  Receive-side checker for the 0,1,3,7,6,4 repeating counter sequence.
//  - Samples a 3-bit code stream and decodes each legal code to its position 0..5.
//  - Acquires lock after LOCK_COUNT consecutive correct successors.
//  - Flywheels through isolated errors; drops lock after ERR_LIMIT consecutive errors.
//  - Sits downstream of the sequence counter and reports lock, position and error statistics.
// PARAMETERS
//  LOCK_COUNT  3   consecutive correct samples needed to declare lock (>=1)
//  ERR_LIMIT   2   consecutive bad samples while locked before lock is dropped (>=1)
//  CNT_W       16  width of the saturating error counter
// PORTS
//  clk        in   1      clock, all logic on posedge
//  rst        in   1      asynchronous, active-low reset
//  in_valid   in   1      in_code is sampled this cycle
//  in_code    in   3      received sequence code
//  clr_cnt    in   1      synchronous clear of err_cnt
//  locked     out  1      1 while the FSM is in LOCKED or HOLD
//  idx_valid  out  1      idx is valid (registered, 1 cycle after a legal sampled code)
//  idx        out  3      decoded position of last legal sample: 0->0, 1->1, 3->2, 7->3, 6->4, 4->5
//  exp_code   out  3      code expected at the next valid sample
//  err_pulse  out  1      one-cycle pulse per erroneous sample
//  err_cnt    out  CNT_W  saturating count of erroneous samples
// BEHAVIOUR
//  Reset (rst=0, asynchronous)
//   - state=HUNT, all outputs 0 (exp_code=0).
//   - Reset applied mid-operation aborts all state immediately.
//  Sampling and latency
//   - All outputs are registered; each reflects a sample one cycle later.
//   - in_valid=0: no state or counter change; idx_valid=0; err_pulse=0.
//  Codes
//   - Illegal codes: 2 and 5. An illegal code gives idx_valid=0, err_pulse=1.
//   - Successor function: succ(0)=1, 1->3, 3->7, 7->6, 6->4, 4->0 (wraps).
//  Error definition
//   - HUNT/ACQUIRE: an illegal code.
//   - LOCKED/HOLD: any code != exp_code.
//  FSM transitions on a valid sample
//   - HUNT, legal code: exp=succ(code), good=1; go to ACQUIRE, or to LOCKED if LOCK_COUNT==1.
//   - HUNT, illegal code: stay in HUNT.
//   - ACQUIRE, match: exp=succ(exp), good++; go to LOCKED when good reaches LOCK_COUNT.
//   - ACQUIRE, legal mismatch: reseed exp=succ(code), good=1; no error.
//   - ACQUIRE, illegal code: go to HUNT.
//   - LOCKED, match: stay; exp=succ(exp).
//   - LOCKED, mismatch: exp=succ(exp) (flywheel), bad=1; go to HOLD, or to HUNT if ERR_LIMIT==1.
//   - HOLD, match: exp=succ(exp), bad=0; go to LOCKED.
//   - HOLD, mismatch: exp=succ(exp), bad++; go to HUNT when bad reaches ERR_LIMIT.
//  Outputs
//   - locked rises the cycle after the LOCK_COUNT-th good sample.
//   - locked falls the cycle after the ERR_LIMIT-th bad sample.
//  err_cnt
//   - Saturates at all-ones.
//   - clr_cnt together with an error in the same cycle: err_cnt=1.
//   - clr_cnt without an error: err_cnt=0.
//  Counters
//   - good and bad are sized with $clog2(param+1) and never wrap.
// STRUCTURE
//  Package seq_pkg:
//   - state_t enum {HUNT, ACQUIRE, LOCKED, HOLD}
//   - code constants C0, C1, C3, C7, C6, C4
//   - functions code2idx(), is_legal(), succ()
//  Sub-module seq_code_decode: combinational code -> {legal, idx, succ}.
//  Top level: FSM, good/bad counters, exp register, err_cnt.
// TESTING (LOCK_COUNT=3, ERR_LIMIT=2, CNT_W=16 unless stated)
//  1. rst=0 mid-stream for 2 cycles -> all outputs 0 immediately; state=HUNT.
//  2. After reset, feed 0,1,3 -> idx=0,1,2, each one cycle after its sample;
//     locked=1 one cycle after code 3; exp_code=7.
//  3. Locked, feed 7,6,4,0,1 -> idx=3,4,5,0,1; err_pulse stays 0; wrap 4->0 accepted.
//  4. Locked with exp_code=7, feed 2 then 6 -> err_pulse for one cycle, err_cnt=1, locked stays 1;
//     6 matches the flywheel and returns the FSM to LOCKED.
//  5. Locked with exp_code=7, feed 0,0 -> locked=0 after the second sample (HUNT);
//     then feed 1,3,7 -> relock.
//  6. CNT_W=2: 5 illegal codes -> err_cnt saturates at 3;
//     clr_cnt together with an error -> err_cnt=1.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types, code constants and code helpers for the 0,1,3,7,6,4 sequence checker.
package seq_pkg;

    typedef enum logic [1:0] {
        HUNT,
        ACQUIRE,
        LOCKED,
        HOLD
    } state_t;

    localparam logic [2:0] C0 = 3'd0;
    localparam logic [2:0] C1 = 3'd1;
    localparam logic [2:0] C3 = 3'd3;
    localparam logic [2:0] C7 = 3'd7;
    localparam logic [2:0] C6 = 3'd6;
    localparam logic [2:0] C4 = 3'd4;

    // Codes 2 and 5 never occur in the sequence
    function automatic logic is_legal(input logic [2:0] code);
        return (code != 3'd2) && (code != 3'd5);
    endfunction

    function automatic logic [2:0] code2idx(input logic [2:0] code);
        logic [2:0] idx;
        case (code)
            C0:      idx = 3'd0;
            C1:      idx = 3'd1;
            C3:      idx = 3'd2;
            C7:      idx = 3'd3;
            C6:      idx = 3'd4;
            C4:      idx = 3'd5;
            default: idx = 3'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [2:0] succ(input logic [2:0] code);
        logic [2:0] nxt;
        case (code)
            C0:      nxt = C1;
            C1:      nxt = C3;
            C3:      nxt = C7;
            C7:      nxt = C6;
            C6:      nxt = C4;
            C4:      nxt = C0;
            default: nxt = C0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/seq_code_decode.sv
// Combinational decode of a received code into legality, position and successor.
module seq_code_decode
    import seq_pkg::*;
(
    input  logic [2:0] code,
    output logic       code_legal,
    output logic [2:0] code_idx,
    output logic [2:0] code_succ
);

    always_comb begin
        code_legal = is_legal(code);
        code_idx   = code2idx(code);
        code_succ  = succ(code);
    end

endmodule

// File: rtl/seq_lock_checker.sv
// Receive-side lock checker for the 0,1,3,7,6,4 sequence: hunts, acquires, flywheels
// through isolated errors and keeps a saturating error count.
module seq_lock_checker
    import seq_pkg::*;
#(
    parameter int LOCK_COUNT = 3,
    parameter int ERR_LIMIT  = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [2:0]       in_code,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             idx_valid,
    output logic [2:0]       idx,
    output logic [2:0]       exp_code,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W  = $clog2(ERR_LIMIT + 1);

    state_t            state;
    logic [GOOD_W-1:0] good;
    logic [BAD_W-1:0]  bad;

    logic              code_legal;
    logic [2:0]        code_idx;
    logic [2:0]        code_succ;
    logic [2:0]        exp_succ;
    logic              match;
    logic              err;
    logic [GOOD_W-1:0] good_inc;
    logic [BAD_W-1:0]  bad_inc;

    seq_code_decode u_decode (
        .code       (in_code),
        .code_legal (code_legal),
        .code_idx   (code_idx),
        .code_succ  (code_succ)
    );

    // exp_code is always a legal code, so equality alone implies legality
    always_comb begin
        exp_succ = succ(exp_code);
        match    = (in_code == exp_code);
        good_inc = good + GOOD_W'(1);
        bad_inc  = bad + BAD_W'(1);
        err      = 1'b0;
        if (in_valid) begin
            if (state == HUNT || state == ACQUIRE) begin
                err = !code_legal;
            end else begin
                err = !match;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= HUNT;
            good      <= '0;
            bad       <= '0;
            locked    <= 1'b0;
            idx_valid <= 1'b0;
            idx       <= '0;
            exp_code  <= '0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            idx_valid <= in_valid && code_legal;
            err_pulse <= err;
            if (in_valid && code_legal) begin
                idx <= code_idx;
            end

            // An error coincident with a clear leaves exactly that one error counted
            if (err) begin
                if (clr_cnt) begin
                    err_cnt <= CNT_W'(1);
                end else if (err_cnt != '1) begin
                    err_cnt <= err_cnt + CNT_W'(1);
                end
            end else if (clr_cnt) begin
                err_cnt <= '0;
            end

            if (in_valid) begin
                unique case (state)
                    HUNT: begin
                        if (code_legal) begin
                            exp_code <= code_succ;
                            good     <= GOOD_W'(1);
                            if (LOCK_COUNT == 1) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end else begin
                                state <= ACQUIRE;
                            end
                        end
                    end
                    ACQUIRE: begin
                        if (!code_legal) begin
                            state <= HUNT;
                        end else if (match) begin
                            exp_code <= exp_succ;
                            good     <= good_inc;
                            if (good_inc == GOOD_W'(LOCK_COUNT)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            exp_code <= code_succ;
                            good     <= GOOD_W'(1);
                        end
                    end
                    LOCKED: begin
                        exp_code <= exp_succ;
                        if (!match) begin
                            bad <= BAD_W'(1);
                            if (ERR_LIMIT == 1) begin
                                state  <= HUNT;
                                locked <= 1'b0;
                            end else begin
                                state <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        exp_code <= exp_succ;
                        if (match) begin
                            bad   <= '0;
                            state <= LOCKED;
                        end else begin
                            bad <= bad_inc;
                            if (bad_inc == BAD_W'(ERR_LIMIT)) begin
                                state  <= HUNT;
                                locked <= 1'b0;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_lock_checker.sv
// Bench for seq_lock_checker: directed scenarios then random traffic, two parameterisations
// checked against a position-based reference model.
module tb_seq_lock_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_code = 3'd0;
    logic        clr_cnt = 1'b0;

    logic        a_locked, a_idx_valid, a_err_pulse;
    logic [2:0]  a_idx, a_exp_code;
    logic [15:0] a_err_cnt;
    logic        b_locked, b_idx_valid, b_err_pulse;
    logic [2:0]  b_idx, b_exp_code;
    logic [1:0]  b_err_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_lock_checker #(.LOCK_COUNT(3), .ERR_LIMIT(2), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code), .clr_cnt(clr_cnt),
        .locked(a_locked), .idx_valid(a_idx_valid), .idx(a_idx), .exp_code(a_exp_code),
        .err_pulse(a_err_pulse), .err_cnt(a_err_cnt)
    );

    seq_lock_checker #(.LOCK_COUNT(1), .ERR_LIMIT(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code), .clr_cnt(clr_cnt),
        .locked(b_locked), .idx_valid(b_idx_valid), .idx(b_idx), .exp_code(b_exp_code),
        .err_pulse(b_err_pulse), .err_cnt(b_err_cnt)
    );

    // Model tracks the expected position in the sequence rather than the code itself
    localparam int M_HUNT = 0, M_ACQ = 1, M_LOCK = 2, M_HOLD = 3;
    int seq_tab[6] = '{0, 1, 3, 7, 6, 4};

    typedef struct {
        int mode;
        int exp_pos;
        int good;
        int bad;
        int cnt;
        int ix;
        bit lk;
        bit iv;
        bit ep;
    } model_t;

    model_t ma, mb;

    function automatic int pos_of(input int code);
        for (int i = 0; i < 6; i++) if (seq_tab[i] == code) return i;
        return -1;
    endfunction

    function automatic model_t model_reset();
        model_t m;
        m.mode = M_HUNT; m.exp_pos = 0; m.good = 0; m.bad = 0; m.cnt = 0; m.ix = 0;
        m.lk = 0; m.iv = 0; m.ep = 0;
        return m;
    endfunction

    function automatic model_t model_step(input model_t m, input bit v, input int code,
                                          input bit clr, input int lc, input int el, input int cw);
        model_t n = m;
        int p = pos_of(code);
        bit e = 0;
        int cmax = (1 << cw) - 1;
        n.iv = 0;
        if (v) begin
            if (p >= 0) begin
                n.iv = 1;
                n.ix = p;
            end
            case (m.mode)
                M_HUNT: begin
                    if (p < 0) e = 1;
                    else begin
                        n.exp_pos = (p + 1) % 6;
                        n.good = 1;
                        n.mode = (lc == 1) ? M_LOCK : M_ACQ;
                    end
                end
                M_ACQ: begin
                    if (p < 0) begin
                        e = 1;
                        n.mode = M_HUNT;
                    end else if (p == m.exp_pos) begin
                        n.exp_pos = (m.exp_pos + 1) % 6;
                        n.good = m.good + 1;
                        if (n.good == lc) n.mode = M_LOCK;
                    end else begin
                        n.exp_pos = (p + 1) % 6;
                        n.good = 1;
                    end
                end
                M_LOCK: begin
                    n.exp_pos = (m.exp_pos + 1) % 6;
                    if (p != m.exp_pos) begin
                        e = 1;
                        n.bad = 1;
                        n.mode = (el == 1) ? M_HUNT : M_HOLD;
                    end
                end
                default: begin
                    n.exp_pos = (m.exp_pos + 1) % 6;
                    if (p == m.exp_pos) begin
                        n.bad = 0;
                        n.mode = M_LOCK;
                    end else begin
                        e = 1;
                        n.bad = m.bad + 1;
                        if (n.bad == el) n.mode = M_HUNT;
                    end
                end
            endcase
        end
        n.ep = e;
        if (e) n.cnt = clr ? 1 : ((m.cnt == cmax) ? cmax : m.cnt + 1);
        else if (clr) n.cnt = 0;
        n.lk = (n.mode == M_LOCK) || (n.mode == M_HOLD);
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        chk("a.locked",    32'(a_locked),    32'(ma.lk));
        chk("a.idx_valid", 32'(a_idx_valid), 32'(ma.iv));
        chk("a.idx",       32'(a_idx),       ma.ix);
        chk("a.exp_code",  32'(a_exp_code),  seq_tab[ma.exp_pos]);
        chk("a.err_pulse", 32'(a_err_pulse), 32'(ma.ep));
        chk("a.err_cnt",   32'(a_err_cnt),   ma.cnt);
        chk("b.locked",    32'(b_locked),    32'(mb.lk));
        chk("b.idx_valid", 32'(b_idx_valid), 32'(mb.iv));
        chk("b.idx",       32'(b_idx),       mb.ix);
        chk("b.exp_code",  32'(b_exp_code),  seq_tab[mb.exp_pos]);
        chk("b.err_pulse", 32'(b_err_pulse), 32'(mb.ep));
        chk("b.err_cnt",   32'(b_err_cnt),   mb.cnt);
    endtask

    task automatic step(input bit v, input int code, input bit clr);
        in_valid = v;
        in_code  = 3'(code);
        clr_cnt  = clr;
        @(posedge clk);
        ma = model_step(ma, v, code, clr, 3, 2, 16);
        mb = model_step(mb, v, code, clr, 1, 1, 2);
        #1;
        check_all();
    endtask

    // Reset is asserted between edges so its asynchronous effect is observed directly
    task automatic apply_reset();
        rst = 1'b0;
        #1;
        ma = model_reset();
        mb = model_reset();
        check_all();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;
    endtask

    initial begin
        int code;
        ma = model_reset();
        mb = model_reset();
        #2;
        apply_reset();

        // Acquire: 0,1,3 then locked with exp 7
        step(1, 0, 0); step(1, 1, 0); step(1, 3, 0);
        chk("t2.locked", 32'(a_locked), 1);
        chk("t2.exp", 32'(a_exp_code), 7);
        chk("t2.idx", 32'(a_idx), 2);

        // Locked run including the 4 -> 0 wrap
        step(1, 7, 0); step(1, 6, 0); step(1, 4, 0); step(1, 0, 0); step(1, 1, 0);
        chk("t3.idx", 32'(a_idx), 1);
        chk("t3.errcnt", 32'(a_err_cnt), 0);
        step(1, 3, 0);

        // Single error flywheel
        step(1, 2, 0);
        chk("t4.pulse", 32'(a_err_pulse), 1);
        chk("t4.locked", 32'(a_locked), 1);
        chk("t4.errcnt", 32'(a_err_cnt), 1);
        step(1, 6, 0);
        chk("t4.pulse_off", 32'(a_err_pulse), 0);
        chk("t4.relocked", 32'(a_locked), 1);
        step(1, 4, 0); step(1, 0, 0); step(1, 1, 0); step(1, 3, 0);
        chk("t5.exp", 32'(a_exp_code), 7);

        // Two consecutive errors drop lock, then relock
        step(1, 0, 0);
        chk("t5.hold", 32'(a_locked), 1);
        step(1, 0, 0);
        chk("t5.drop", 32'(a_locked), 0);
        step(1, 1, 0); step(1, 3, 0);
        chk("t5.acq", 32'(a_locked), 0);
        step(1, 7, 0);
        chk("t5.relock", 32'(a_locked), 1);

        // Idle cycles, then mid-stream reset
        step(0, 2, 0); step(0, 6, 0);
        apply_reset();

        // Saturation on the narrow counter and clear-with-error
        for (int i = 0; i < 5; i++) step(1, (i % 2 == 0) ? 2 : 5, 0);
        chk("t6.sat", 32'(b_err_cnt), 3);
        chk("t6.a_cnt", 32'(a_err_cnt), 5);
        step(1, 2, 1);
        chk("t6.clr_err", 32'(b_err_cnt), 1);
        step(1, 0, 1);
        chk("t6.clr", 32'(a_err_cnt), 0);

        // Random traffic biased towards the expected successor
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) apply_reset();
            if ($urandom_range(0, 9) < 7) code = seq_tab[ma.exp_pos];
            else code = int'($urandom_range(0, 7));
            step($urandom_range(0, 9) != 0, code, $urandom_range(0, 31) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
